jtgng_objdma_dbuf: RTL

- Parametrised successor to the single-buffer object DMA.
- Copies a configurable-length object table from the shared CPU bus into one bank of an internal ping-pong object buffer during vertical blank; the sprite scanner reads the other bank.
- Adds bank swap on completion, pause on bus_ack loss, abort on blank end, a programmable copy rate and status outputs.
- Sits between the main-CPU bus arbiter and the object line scanner.

---
 rtl/jtgng_objdma_pkg.sv | 13 +
 rtl/jtgng_dual_ram.sv | 28 ++
 rtl/jtgng_objdma_dbuf.sv | 110 +++++++++++
 3 files changed

// File: rtl/jtgng_objdma_pkg.sv
// rtl/jtgng_objdma_pkg.sv - shared state encoding and defaults for the object DMA
package jtgng_objdma_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_BUSY = 2'd2,
    ST_SWAP = 2'd3
  } objdma_state_t;

  localparam logic [8:0] OBJMAX_GNG = 9'h180;

endpackage

// File: rtl/jtgng_dual_ram.sv
// rtl/jtgng_dual_ram.sv - simple dual-port RAM, write on clk, registered read on clk_en
module jtgng_dual_ram #(
  parameter int dw = 8,
  parameter int aw = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clk_en,
  input  logic [dw-1:0] data,
  input  logic [aw-1:0] rd_addr,
  input  logic [aw-1:0] wr_addr,
  input  logic          we,
  output logic [dw-1:0] q
);

  logic [dw-1:0] mem [0:2**aw-1];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= data;
  end

  // Only the output register is reset; the array keeps its contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      q <= '0;
    else if (clk_en) q <= mem[rd_addr];
  end

endmodule

// File: rtl/jtgng_objdma_dbuf.sv
// rtl/jtgng_objdma_dbuf.sv - object table DMA into a ping-pong buffer during vertical blank
module jtgng_objdma_dbuf
  import jtgng_objdma_pkg::*;
#(
  parameter int            AW     = 9,
  parameter int            DW     = 8,
  parameter logic [AW-1:0] OBJMAX = AW'(OBJMAX_GNG),
  parameter int            CPB    = 2,
  parameter bit            DBUF   = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cen,
  input  logic          LVBL,
  input  logic          OKOUT,
  input  logic          bus_ack,
  input  logic [DW-1:0] DB,
  input  logic [AW-1:0] pre_scan,
  output logic [AW-1:0] AB,
  output logic          bus_req,
  output logic          blen,
  output logic [DW-1:0] ram_dout,
  output logic          bank,
  output logic          done,
  output logic          aborted
);

  localparam logic [1:0] DIV_LAST = 2'(CPB - 1);

  objdma_state_t st;
  logic [1:0]    div;
  logic          wbank;
  logic          wr_tick;
  logic          we;

  assign wbank   = DBUF ? ~bank : 1'b0;
  assign wr_tick = (st == ST_BUSY) && (div == DIV_LAST) && bus_ack;
  assign we      = cen && wr_tick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st      <= ST_IDLE;
      AB      <= '0;
      div     <= '0;
      bus_req <= 1'b0;
      blen    <= 1'b0;
      bank    <= 1'b0;
      done    <= 1'b0;
      aborted <= 1'b0;
    end else if (cen) begin
      done <= 1'b0;
      case (st)
        ST_IDLE: begin
          if (OKOUT) begin
            bus_req <= 1'b1;
            st      <= ST_WAIT;
          end else begin
            bus_req <= 1'b0;
            blen    <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (bus_ack && !LVBL) begin
            blen    <= 1'b1;
            AB      <= '0;
            div     <= '0;
            aborted <= 1'b0;
            st      <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (bus_ack) div <= (div == DIV_LAST) ? 2'd0 : div + 2'd1;
          if (wr_tick) AB <= AB + AW'(1);
          // The final write beats a coincident end of blank.
          if (wr_tick && AB == OBJMAX) begin
            blen    <= 1'b0;
            bus_req <= 1'b0;
            st      <= ST_SWAP;
          end else if (LVBL) begin
            blen    <= 1'b0;
            bus_req <= 1'b0;
            aborted <= 1'b1;
            st      <= ST_IDLE;
          end
        end
        ST_SWAP: begin
          done <= 1'b1;
          if (DBUF) bank <= ~bank;
          st <= ST_IDLE;
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

  jtgng_dual_ram #(
    .dw(DW),
    .aw(AW + 1)
  ) u_ram (
    .clk    (clk),
    .rst_n  (rst_n),
    .clk_en (cen),
    .data   (DB),
    .rd_addr({bank, pre_scan}),
    .wr_addr({wbank, AB}),
    .we     (we),
    .q      (ram_dout)
  );

endmodule
